param_shift_unit: RTL and testbench

//  Parametrised multi-mode shift register for the sequential multiplier/divider datapath.

---
 rtl/param_shift_unit_pkg.sv | 5 +
 rtl/param_shift_unit_if.sv | 29 ++
 rtl/param_shift_unit_step.sv | 21 ++
 rtl/param_shift_unit.sv | 82 ++++++++
 tb/tb_param_shift_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/param_shift_unit_pkg.sv
// shift_pkg: shift modes and FSM states shared by the shift unit files
package shift_pkg;
  typedef enum logic [1:0] {ASR = 2'd0, LSR = 2'd1, LSL = 2'd2, ROR = 2'd3} shift_mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} shift_state_e;
endpackage

// File: rtl/param_shift_unit_if.sv
// param_shift_unit_if: command/data bus of the shift unit (sticky present only with SHIFT_STICKY_EN)
interface param_shift_unit_if #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
);
  logic          load;
  logic [W-1:0]  data_in;
  logic          shift;
  logic          start;
  logic [CW-1:0] shamt;
  logic [1:0]    mode;
  logic          serial_in;
  logic [W-1:0]  data_out;
  logic          serial_out;
  logic          busy;
  logic          done;
`ifdef SHIFT_STICKY_EN
  logic          sticky;
  modport master (output load, data_in, shift, start, shamt, mode, serial_in,
                  input data_out, serial_out, busy, done, sticky);
  modport slave  (input load, data_in, shift, start, shamt, mode, serial_in,
                  output data_out, serial_out, busy, done, sticky);
`else
  modport master (output load, data_in, shift, start, shamt, mode, serial_in,
                  input data_out, serial_out, busy, done);
  modport slave  (input load, data_in, shift, start, shamt, mode, serial_in,
                  output data_out, serial_out, busy, done);
`endif
endinterface

// File: rtl/param_shift_unit_step.sv
// shift_step: combinational one-step shifter returning the shifted value and the bit shifted out
module shift_step
  import shift_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] b_i,
  input  shift_mode_e  mode_i,
  input  logic         serial_i,
  output logic [W-1:0] nxt_o,
  output logic         out_o
);
  // LSL is the only mode that drops the MSB; every other mode drops the LSB
  always_comb begin
    nxt_o = mode_i == ASR ? {b_i[W-1], b_i[W-1:1]} :
            mode_i == LSR ? {serial_i, b_i[W-1:1]} :
            mode_i == LSL ? {b_i[W-2:0], serial_i} :
                            {b_i[0], b_i[W-1:1]};
    out_o = mode_i == LSL ? b_i[W-1] : b_i[0];
  end
endmodule

// File: rtl/param_shift_unit.sv
// param_shift_unit: W-bit four-mode shifter with immediate step and multi-cycle N-bit shift; optional SHIFT_STICKY_EN
module param_shift_unit
  import shift_pkg::*;
#(
  parameter  int W  = 8,
  localparam int CW = $clog2(W + 1)
) (
  input logic               clk,
  input logic               rst,
  param_shift_unit_if.slave bus
);
  shift_state_e  state_q, state_d;
  shift_mode_e   mode_q, mode_d, step_mode;
  logic [W-1:0]  data_q, data_d, step_nxt;
  logic [CW-1:0] cnt_q, cnt_d, amt;
  logic          sout_q, sout_d, step_out, stepping;
  assign amt       = bus.shamt > CW'(W) ? CW'(W) : bus.shamt;
  assign step_mode = state_q == IDLE ? shift_mode_e'(bus.mode) : mode_q;
  assign stepping  = (state_q == IDLE && bus.shift) || state_q == SHIFT;
  shift_step #(.W(W)) u_step (
    .b_i     (data_q),
    .mode_i  (step_mode),
    .serial_i(bus.serial_in),
    .nxt_o   (step_nxt),
    .out_o   (step_out)
  );
  // next state: shift beats load beats start in IDLE; commands are ignored outside IDLE
  always_comb begin
    data_d  = data_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    state_d = state_q;
    if (stepping) begin
      data_d = step_nxt;
      sout_d = step_out;
    end
    if (state_q == SHIFT) begin
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == CW'(1) ? DONE : SHIFT;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (!bus.shift && bus.load) begin
      data_d = bus.data_in;
    end else if (!bus.shift && bus.start) begin
      mode_d  = shift_mode_e'(bus.mode);
      cnt_d   = amt;
      state_d = amt != '0 ? SHIFT : DONE;
    end
  end
  // state, data and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= ASR;
      data_q  <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
    end
  end
  assign bus.data_out   = data_q;
  assign bus.serial_out = sout_q;
  assign bus.busy       = state_q == SHIFT;
  assign bus.done       = state_q == DONE;
`ifdef SHIFT_STICKY_EN
  logic sticky_q, sticky_d, sticky_clr;
  assign sticky_clr = state_q == IDLE && !bus.shift && (bus.load || bus.start);
  assign sticky_d   = sticky_clr ? 1'b0 : stepping ? sticky_q | step_out : sticky_q;
  // sticky accumulates every shifted-out bit until the next load or start
  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end
  assign bus.sticky = sticky_q;
`endif
endmodule

// File: tb/tb_param_shift_unit.sv
// tb_param_shift_unit: randomized scoreboard bench for param_shift_unit (W=8), optional SHIFT_STICKY_EN
module tb_param_shift_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  param_shift_unit_if #(.W(8)) bus ();
  param_shift_unit #(.W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int         due;
    logic [7:0] data;
    logic       sout;
    logic       busy;
    logic       done;
    logic       sticky;
    string      tag;
  } exp_t;
  exp_t sb[$];

  logic [7:0] m_data = '0;
  logic       m_sout = 1'b0;
  logic       m_sticky = 1'b0;

  function automatic logic [8:0] mstep(input logic [1:0] md, input logic si, input logic [7:0] b);
    logic [7:0] r;
    case (md)
      2'd0:    r = $signed(b) >>> 1;
      2'd1:    r = (b >> 1) | {si, 7'b0};
      2'd2:    r = (b << 1) | {7'b0, si};
      default: r = (b >> 1) | (b << 7);
    endcase
    return {md == 2'd2 ? b[7] : b[0], r};
  endfunction

  task automatic push(input int due, input logic busy, input logic done, input string tag);
    exp_t e;
    e.due = due; e.data = m_data; e.sout = m_sout; e.busy = busy; e.done = done;
    e.sticky = m_sticky; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic clear_cmds();
    bus.load = 1'b0; bus.shift = 1'b0; bus.start = 1'b0;
  endtask

  task automatic apply_rst(input string tag);
    @(posedge clk); #1;
    rst = 1'b1;
    m_data = '0; m_sout = 1'b0; m_sticky = 1'b0;
    push(cyc + 1, 1'b0, 1'b0, tag);
    @(posedge clk); #1;
    rst = 1'b0;
    push(cyc + 1, 1'b0, 1'b0, {tag, "_after"});
  endtask

  // kind bits: [2] shift, [1] load, [0] start; noise pulses commands while the unit is busy/done
  task automatic issue(input logic [2:0] kind, input logic [1:0] md, input logic si,
                       input logic [7:0] d, input logic [3:0] sa, input bit noise, input string tag);
    int n, k;
    logic [8:0] r;
    @(posedge clk); #1;
    bus.shift = kind[2]; bus.load = kind[1]; bus.start = kind[0];
    bus.mode = md; bus.serial_in = si; bus.data_in = d; bus.shamt = sa;
    n = cyc;
    if (kind[2]) begin
      r = mstep(md, si, m_data);
      m_data = r[7:0]; m_sout = r[8]; m_sticky = m_sticky | r[8];
      push(n + 1, 1'b0, 1'b0, tag);
    end else if (kind[1]) begin
      m_data = d; m_sticky = 1'b0;
      push(n + 1, 1'b0, 1'b0, tag);
    end else if (kind[0]) begin
      k = sa > 8 ? 8 : int'(sa);
      m_sticky = 1'b0;
      for (int i = 0; i < k; i++) begin
        push(n + 1 + i, 1'b1, 1'b0, tag);
        r = mstep(md, si, m_data);
        m_data = r[7:0]; m_sout = r[8]; m_sticky = m_sticky | r[8];
      end
      push(n + 1 + k, 1'b0, 1'b1, {tag, "_done"});
      push(n + 2 + k, 1'b0, 1'b0, {tag, "_idle"});
      for (int j = 0; j <= k; j++) begin
        @(posedge clk); #1;
        if (noise) begin
          bus.shift = 1'($urandom); bus.load = 1'($urandom); bus.start = 1'($urandom);
          bus.mode = 2'($urandom); bus.data_in = 8'($urandom); bus.shamt = 4'($urandom);
        end else clear_cmds();
      end
    end else begin
      push(n + 1, 1'b0, 1'b0, tag);
    end
    @(posedge clk); #1;
    clear_cmds();
  endtask

  // monitor: compare every expectation that falls due in this cycle
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      exp_t e;
      logic act_st;
      e = sb.pop_front();
`ifdef SHIFT_STICKY_EN
      act_st = bus.sticky;
`else
      act_st = e.sticky;
`endif
      compared++;
      if (e.due != cyc || bus.data_out !== e.data || bus.serial_out !== e.sout ||
          bus.busy !== e.busy || bus.done !== e.done || act_st !== e.sticky) begin
        mismatched++;
        $display("FAIL %s cyc=%0d: got data=%h so=%b busy=%b done=%b sticky=%b, want data=%h so=%b busy=%b done=%b sticky=%b (due %0d)",
                 e.tag, cyc, bus.data_out, bus.serial_out, bus.busy, bus.done, act_st,
                 e.data, e.sout, e.busy, e.done, e.sticky, e.due);
      end
    end
  end

  initial begin
    clear_cmds();
    bus.mode = 2'd0; bus.serial_in = 1'b0; bus.data_in = '0; bus.shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    push(cyc, 1'b0, 1'b0, "reset_state");
    rst = 1'b0;
    issue(3'b010, 2'd0, 1'b0, 8'hA5, 4'd0, 1'b0, "load_a5");
    apply_rst("rst_after_load");
    issue(3'b010, 2'd0, 1'b0, 8'h3C, 4'd0, 1'b0, "load_3c");
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = 2'd3; bus.shamt = 4'd8;
    m_sticky = 1'b0;
    @(posedge clk); #1;
    clear_cmds();
    push(cyc, 1'b1, 1'b0, "busy_before_rst");
    apply_rst("rst_mid_busy");
    issue(3'b010, 2'd0, 1'b0, 8'h96, 4'd0, 1'b0, "load_96");
    issue(3'b100, 2'd0, 1'b0, 8'h00, 4'd0, 1'b0, "asr_step_96");
    issue(3'b010, 2'd0, 1'b0, 8'h81, 4'd0, 1'b0, "load_81");
    issue(3'b100, 2'd2, 1'b1, 8'h00, 4'd0, 1'b0, "lsl_step_81");
    issue(3'b010, 2'd0, 1'b0, 8'h80, 4'd0, 1'b0, "load_80");
    issue(3'b001, 2'd0, 1'b0, 8'h00, 4'd3, 1'b0, "asr3_80");
    issue(3'b010, 2'd0, 1'b0, 8'h81, 4'd0, 1'b0, "load_81b");
    issue(3'b001, 2'd3, 1'b0, 8'h00, 4'd12, 1'b0, "ror12_81");
    issue(3'b010, 2'd0, 1'b0, 8'h80, 4'd0, 1'b0, "load_80b");
    issue(3'b001, 2'd0, 1'b0, 8'h00, 4'd8, 1'b1, "asr8_80");
    issue(3'b001, 2'd1, 1'b0, 8'h00, 4'd0, 1'b1, "start_zero");
    issue(3'b001, 2'd2, 1'b1, 8'h00, 4'd5, 1'b1, "lsl5_noise");
    issue(3'b111, 2'd1, 1'b1, 8'h5A, 4'd4, 1'b0, "prio_shift");
    issue(3'b011, 2'd0, 1'b0, 8'h5A, 4'd4, 1'b0, "prio_load");
    issue(3'b010, 2'd0, 1'b0, 8'h04, 4'd0, 1'b0, "load_04");
    issue(3'b001, 2'd1, 1'b0, 8'h00, 4'd3, 1'b0, "lsr3_04");
    issue(3'b010, 2'd0, 1'b0, 8'h08, 4'd0, 1'b0, "load_08");
    issue(3'b001, 2'd1, 1'b0, 8'h00, 4'd3, 1'b0, "lsr3_08");
    for (int i = 0; i < 150; i++)
      issue(3'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), 4'($urandom),
            1'($urandom), "random");
    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL leftover: got %0d unchecked expectations, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
